// File: rtl/excess3_to_bcd_pkg.sv
// Package for the excess-3 to BCD converter: decode constants, the
// stage-2 result record and a BCD-to-binary helper.
// Optional feature macro: E3DEC_BIN_EN (binary value output).
package excess3_to_bcd_pkg;

  `include "e3_defs.vh"

  // Decoded result of one input byte as held in the output stage.
  typedef struct packed {
    logic [7:0] q;
    logic       err;
  } result_t;

  // tens*10 + units using shifts; inputs are valid BCD digits (0..9).
  function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens,
                                            input logic [3:0] units);
    logic [6:0] t;
    logic [6:0] u;
    t = {3'b000, tens};
    u = {3'b000, units};
    return (t << 3) + (t << 1) + u;
  endfunction

endpackage

// File: rtl/e3_defs.vh
// Shared excess-3 decode constants, pulled into excess3_to_bcd_pkg.
`ifndef E3_DEFS_VH
`define E3_DEFS_VH

// Excess-3 code is the decimal digit plus this offset.
localparam logic [3:0] E3_OFFSET = 4'd3;
// Lowest legal excess-3 code (digit 0).
localparam logic [3:0] E3_MIN    = 4'd3;
// Highest legal excess-3 code (digit 9).
localparam logic [3:0] E3_MAX    = 4'd12;
// Digit value reported for an illegal code.
localparam logic [3:0] BCD_BAD   = 4'hF;

`endif

// File: rtl/e3_digit.sv
// Single excess-3 nibble decoder: legal codes 3..12 map to digits 0..9,
// every other code yields BCD_BAD with the invalid flag raised.
module e3_digit
  import excess3_to_bcd_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] digit,
  output logic       invalid
);

  // Range check and offset removal.
  always_comb begin
    invalid = (code < E3_MIN) || (code > E3_MAX);
    digit   = invalid ? BCD_BAD : (code - E3_OFFSET);
  end

endmodule

// File: rtl/excess3_to_bcd.sv
// Two-stage valid/ready pipeline converting a byte of two packed excess-3
// digits into packed BCD, with an error flag and a saturating count of
// erroneous results delivered.
// Optional feature macro: E3DEC_BIN_EN adds output bin (tens*10+units,
// 7'h7F on error), registered alongside q.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer side (in_valid/a) may not be assumed to hold;
// the output side holds q/err/out_valid (and bin) stable while
// out_valid && !out_ready. A stage loads when it is empty or when its
// contents are leaving in the same cycle.
module excess3_to_bcd
  import excess3_to_bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] q,
  output logic       err,
  input  logic       clr,
  output logic [7:0] err_cnt
`ifdef E3DEC_BIN_EN
  ,
  output logic [6:0] bin
`endif
);

  logic       s1_valid;
  logic [7:0] s1_a;
  logic       in_fire;
  logic       s2_load;
  logic       out_fire;
  logic [3:0] tens_digit;
  logic [3:0] units_digit;
  logic       tens_bad;
  logic       units_bad;
  result_t    s2_next;

  e3_digit u_tens (
    .code    (s1_a[7:4]),
    .digit   (tens_digit),
    .invalid (tens_bad)
  );

  e3_digit u_units (
    .code    (s1_a[3:0]),
    .digit   (units_digit),
    .invalid (units_bad)
  );

  // Handshake and stage-advance decisions.
  always_comb begin
    out_fire    = out_valid && out_ready;
    s2_load     = s1_valid && (!out_valid || out_ready);
    in_ready    = !s1_valid || s2_load;
    in_fire     = in_valid && in_ready;
    s2_next.q   = {tens_digit, units_digit};
    s2_next.err = tens_bad || units_bad;
  end

  // Stage 1: capture the raw input byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= 8'h00;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: register the decoded result; hold it until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= 8'h00;
      err       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      q         <= s2_next.q;
      err       <= s2_next.err;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

`ifdef E3DEC_BIN_EN
  // Binary value of the result, loaded together with q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin <= 7'h00;
    end else if (s2_load) begin
      bin <= s2_next.err ? 7'h7F : bcd_to_bin(tens_digit, units_digit);
    end
  end
`endif

  // Count delivered erroneous results; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'h00;
    end else if (clr) begin
      err_cnt <= 8'h00;
    end else if (out_fire && err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_excess3_to_bcd.sv
// Self-checking bench for excess3_to_bcd: directed cases plus a randomized
// sweep, with an expected-result queue filled on input handshakes and
// drained by an output monitor.
module tb_excess3_to_bcd;

`ifdef E3DEC_BIN_EN
  localparam int W = 16;
`else
  localparam int W = 9;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic       err;
  logic       clr;
  logic [7:0] err_cnt;
`ifdef E3DEC_BIN_EN
  logic [6:0] bin;
`endif

  excess3_to_bcd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .err       (err),
    .clr       (clr),
    .err_cnt   (err_cnt)
`ifdef E3DEC_BIN_EN
    ,
    .bin       (bin)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp;
  int           n_bad;
  int           model_cnt;
  bit           rnd;

  // Reference: decode each nibble from the digit rules with plain integers.
  function automatic logic [W-1:0] model(input logic [7:0] v);
    int t_code;
    int u_code;
    int t_dig;
    int u_dig;
    bit bad;
    int val;
    logic [W-1:0] r;
    t_code = int'(v) / 16;
    u_code = int'(v) % 16;
    bad    = 0;
    if (t_code >= 3 && t_code <= 12) t_dig = t_code - 3;
    else begin t_dig = 15; bad = 1; end
    if (u_code >= 3 && u_code <= 12) u_dig = u_code - 3;
    else begin u_dig = 15; bad = 1; end
    val = bad ? 127 : (t_dig * 10 + u_dig);
    r   = '0;
    r[3:0] = 4'(u_dig);
    r[7:4] = 4'(t_dig);
    r[8]   = bad;
`ifdef E3DEC_BIN_EN
    r[15:9] = 7'(val);
`else
    if (val > 127) r[8] = 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] actual();
`ifdef E3DEC_BIN_EN
    return {bin, err, q};
`else
    return {err, q};
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  // ---------------- input monitor: push expectations ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && in_valid && in_ready) exp_q.push_back(model(a));
    end
  end

  // ---------------- output monitor: pop and compare ----------------
  initial begin
    logic [W-1:0] e;
    model_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        model_cnt = 0;
      end else begin
        if (out_valid && out_ready) begin
          check("err_cnt", 16'(err_cnt), 16'(model_cnt));
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %0h expected none", actual());
          end else begin
            e = exp_q.pop_front();
            check("result", 16'(actual()), 16'(e));
            if (clr) model_cnt = 0;
            else if (e[8] && model_cnt < 255) model_cnt++;
          end
        end else if (clr) begin
          model_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Present one byte and hold it until accepted.
  task automatic send(input logic [7:0] v);
    bit acc;
    acc      = 0;
    in_valid = 1'b1;
    a        = v;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    for (int i = 0; i < 1000 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!acc) timeout("send");
  endtask

  task automatic drain();
    bit done;
    done      = 0;
    rnd       = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (exp_q.size() == 0 && !out_valid) done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) timeout("drain");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rnd       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 8'h00;
    out_ready = 1'b0;
    clr       = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_q", 16'(q), 16'h00);
    check("rst_err", 16'(err), 16'h0);
    check("rst_err_cnt", 16'(err_cnt), 16'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 16'(in_ready), 16'h1);

    // Latency: 8'h33 -> 8'h00 two cycles after presentation.
    out_ready = 1'b1;
    send(8'h33);
    check("lat_not_yet", 16'(out_valid), 16'h0);
    @(posedge clk);
    #1;
    check("lat_valid", 16'(out_valid), 16'h1);
    check("lat_q", 16'(q), 16'h00);
    drain();

    // Largest digits and first error.
    send(8'hCC);
    drain();
    check("cnt_before_err", 16'(err_cnt), 16'h00);
    send(8'h3F);
    drain();
    check("cnt_after_err", 16'(err_cnt), 16'h01);

    // Backpressure: two bytes fill the pipe, third waits.
    out_ready = 1'b0;
    send(8'h34);
    send(8'h45);
    in_valid = 1'b1;
    a        = 8'h56;
    cycles(5);
    @(negedge clk);
    check("bp_in_ready", 16'(in_ready), 16'h0);
    check("bp_q_hold", 16'(q), 16'h01);
    check("bp_out_valid", 16'(out_valid), 16'h1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h56);
    drain();

    // Full byte sweep under random output stalls.
    rnd = 1;
    for (int i = 0; i < 256; i++) send(8'(i));
    drain();

    // Random bytes with random input gaps.
    rnd = 1;
    for (int i = 0; i < 200; i++) begin
      send(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) cycles(1);
    end
    drain();

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) send(8'h00);
    drain();
    check("cnt_saturated", 16'(err_cnt), 16'h00FF);

    // Clear coinciding with an erroneous delivery.
    out_ready = 1'b0;
    send(8'hF3);
    @(posedge clk);
    #1;
    check("clr_pending", 16'(out_valid), 16'h1);
    out_ready = 1'b1;
    clr       = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_wins", 16'(err_cnt), 16'h00);
    drain();

    // Reset with both stages occupied.
    send(8'h3F);
    drain();
    check("cnt_pre_reset", 16'(err_cnt), 16'h01);
    out_ready = 1'b0;
    send(8'h34);
    send(8'h45);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 16'(out_valid), 16'h0);
    check("mid_rst_err_cnt", 16'(err_cnt), 16'h00);
    @(negedge clk);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cycles(5);
    check("post_rst_out_valid", 16'(out_valid), 16'h0);
    check("post_rst_in_ready", 16'(in_ready), 16'h1);

    // One last conversion after reset.
    send(8'h7A);
    drain();
    check("queue_empty", 16'(exp_q.size()), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
